// File: rtl/regfile_sequencer.sv
// regfile_sequencer: sequences a 4x8 single-read-port register file through read-read-execute-writeback; REGSEQ_FLAGS_EN adds flag_z/flag_c outputs
module regfile_sequencer (
   input  logic       clk,
   input  logic       reset_b,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [1:0] cmd_rd,
   input  logic [1:0] cmd_ra,
   input  logic [1:0] cmd_rb,
   input  logic [7:0] cmd_imm,
   output logic [1:0] rf_read_address,
   input  logic [7:0] rf_read_data,
   output logic [1:0] rf_write_address,
   output logic [7:0] rf_write_data,
   output logic       rf_write_enable,
   output logic       done,
   output logic [7:0] result
`ifdef REGSEQ_FLAGS_EN
   ,
   output logic       flag_z,
   output logic       flag_c
`endif
);
   localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_AND = 2'd2, OP_LDI = 2'd3;
   typedef enum logic [1:0] {IDLE, READ_A, READ_B, WRITE} state_t;
   state_t state, next;
   logic [1:0] op, rd, ra, rb;
   logic [7:0] imm, opa, opb, alu;
   logic accept;
   assign accept = cmd_valid && cmd_ready;
   // ALU evaluated on the captured operands; only consumed in WRITE
   always_comb begin
      alu = op == OP_ADD ? opa + opb : op == OP_SUB ? opa - opb : op == OP_AND ? opa & opb : imm;
   end
   // state register; reset aborts any in-flight command
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) state <= IDLE;
      else state <= next;
   end
   // next-state: LDI skips the operand reads
   always_comb begin
      next = state == IDLE ? (accept ? (cmd_op == OP_LDI ? WRITE : READ_A) : IDLE) :
             state == READ_A ? READ_B : state == READ_B ? WRITE : IDLE;
   end
   // outputs decoded from state; buses park at zero when unused
   always_comb begin
      cmd_ready = state == IDLE;
      rf_read_address = state == READ_A ? ra : state == READ_B ? rb : 2'd0;
      rf_write_enable = state == WRITE;
      rf_write_address = state == WRITE ? rd : 2'd0;
      rf_write_data = state == WRITE ? alu : 8'd0;
   end
   // command capture and operand latching from the combinational read port
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         op <= OP_ADD;
         rd <= 2'd0;
         ra <= 2'd0;
         rb <= 2'd0;
         imm <= 8'd0;
         opa <= 8'd0;
         opb <= 8'd0;
      end else begin
         if (accept) begin
            op <= cmd_op;
            rd <= cmd_rd;
            ra <= cmd_ra;
            rb <= cmd_rb;
            imm <= cmd_imm;
         end
         if (state == READ_A) opa <= rf_read_data;
         if (state == READ_B) opb <= rf_read_data;
      end
   end
   // completion: result held until the next writeback, done pulses for one cycle
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         done <= 1'b0;
         result <= 8'd0;
      end else begin
         done <= state == WRITE;
         if (state == WRITE) result <= alu;
      end
   end
`ifdef REGSEQ_FLAGS_EN
   logic carry;
   // carry of an 8-bit add shows as wrap-around; borrow is simply opa < opb
   always_comb begin
      carry = op == OP_ADD ? alu < opa : op == OP_SUB ? opa < opb : 1'b0;
   end
   // flags registered alongside result
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         flag_z <= 1'b0;
         flag_c <= 1'b0;
      end else if (state == WRITE) begin
         flag_z <= alu == 8'd0;
         flag_c <= carry;
      end
   end
`endif
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: scoreboard bench for regfile_sequencer with a behavioural register file
module tb_regfile_sequencer;
   logic clk = 0, reset_b = 0, cmd_valid = 0;
   logic cmd_ready, rf_write_enable, done;
   logic [1:0] cmd_op = 0, cmd_rd = 0, cmd_ra = 0, cmd_rb = 0;
   logic [7:0] cmd_imm = 0;
   logic [1:0] rf_read_address, rf_write_address;
   logic [7:0] rf_read_data, rf_write_data, result;
`ifdef REGSEQ_FLAGS_EN
   logic flag_z, flag_c;
`endif
   logic [7:0] rf [4];
   typedef struct {logic [7:0] r; logic z; logic c;} exp_t;
   exp_t q[$];
   int checks = 0, failures = 0, writes = 0, accepts = 0, exp_writes = 0, exp_accepts = 0, w;
   logic prev_done = 0;

   regfile_sequencer dut (
      .clk(clk), .reset_b(reset_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
      .rf_read_address(rf_read_address), .rf_read_data(rf_read_data),
      .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
      .rf_write_enable(rf_write_enable), .done(done), .result(result)
`ifdef REGSEQ_FLAGS_EN
      , .flag_z(flag_z), .flag_c(flag_c)
`endif
   );

   always #5 clk = ~clk;
   assign rf_read_data = rf[rf_read_address];
   always @(posedge clk) if (rf_write_enable) rf[rf_write_address] <= rf_write_data;
   always @(posedge clk) if (reset_b && rf_write_enable) writes <= writes + 1;
   always @(posedge clk) if (reset_b && cmd_valid && cmd_ready) accepts <= accepts + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // monitor: every done pulse must match the oldest expected writeback
   always @(negedge clk) begin
      if (done) begin
         chk("done_single", prev_done, 0);
         if (q.size() == 0) chk("scoreboard_nonempty", q.size(), 1);
         else begin
            chk("result", result, q[0].r);
`ifdef REGSEQ_FLAGS_EN
            chk("flag_z", flag_z, q[0].z);
            chk("flag_c", flag_c, q[0].c);
`endif
            q.delete(0);
         end
      end
      prev_done <= done;
   end

   task automatic issue(input logic [1:0] op, rd, ra, rb, input logic [7:0] imm, input logic [7:0] r,
                        input logic z, c, input bit wr, output int waited);
      cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm; cmd_valid = 1;
      waited = 0;
      while (!cmd_ready && waited < 20) begin
         chk("busy_without_done", done, 0);
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) chk("accept_timeout", cmd_ready, 1);
      else begin
         exp_accepts++;
         if (wr) begin
            q.push_back('{r, z, c});
            exp_writes++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 0;
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 20);
      chk("done_seen", done, 1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset_b = 1;
      chk("rst_ready", cmd_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_we", rf_write_enable, 0);
      chk("rst_raddr", rf_read_address, 0);
      chk("rst_waddr", rf_write_address, 0);
      chk("rst_wdata", rf_write_data, 0);
      // LDI latency
      issue(2'd3, 2'd2, 2'd0, 2'd0, 8'h5A, 8'h5A, 0, 0, 1, w);
      chk("ldi_we", rf_write_enable, 1);
      chk("ldi_waddr", rf_write_address, 2);
      chk("ldi_wdata", rf_write_data, 8'h5A);
      @(negedge clk);
      chk("ldi_done", done, 1);
      chk("ldi_rf2", rf[2], 8'h5A);
      // ADD with carry, timing
      issue(2'd3, 2'd0, 2'd0, 2'd0, 8'hF0, 8'hF0, 0, 0, 1, w);
      wait_done();
      issue(2'd3, 2'd1, 2'd0, 2'd0, 8'h20, 8'h20, 0, 0, 1, w);
      wait_done();
      issue(2'd0, 2'd3, 2'd0, 2'd1, 8'h00, 8'h10, 0, 1, 1, w);
      chk("add_c1_done", done, 0);
      chk("add_c1_we", rf_write_enable, 0);
      @(negedge clk);
      chk("add_c2_done", done, 0);
      chk("add_c2_raddr", rf_read_address, 1);
      @(negedge clk);
      chk("add_c3_we", rf_write_enable, 1);
      chk("add_c3_wdata", rf_write_data, 8'h10);
      @(negedge clk);
      chk("add_c4_done", done, 1);
      chk("add_c4_ready", cmd_ready, 1);
      chk("add_rf3", rf[3], 8'h10);
      // borrow and zero
      issue(2'd3, 2'd0, 2'd0, 2'd0, 8'h10, 8'h10, 0, 0, 1, w);
      wait_done();
      issue(2'd1, 2'd2, 2'd0, 2'd1, 8'h00, 8'hF0, 0, 1, 1, w);
      wait_done();
      chk("sub_rf2", rf[2], 8'hF0);
      issue(2'd2, 2'd3, 2'd0, 2'd1, 8'h00, 8'h00, 1, 0, 1, w);
      wait_done();
      chk("and_rf3", rf[3], 8'h00);
      // back-to-back with aliasing
      issue(2'd3, 2'd1, 2'd0, 2'd0, 8'h03, 8'h03, 0, 0, 1, w);
      wait_done();
      issue(2'd0, 2'd1, 2'd1, 2'd1, 8'h00, 8'h06, 0, 0, 1, w);
      chk("b2b_wait", w, 0);
      wait_done();
      chk("alias_rf1", rf[1], 8'h06);
      // backpressure: second command held while busy
      issue(2'd3, 2'd0, 2'd0, 2'd0, 8'h11, 8'h11, 0, 0, 1, w);
      issue(2'd0, 2'd2, 2'd0, 2'd0, 8'h00, 8'h22, 0, 0, 1, w);
      chk("bp_ldi_wait", w, 1);
      wait_done();
      issue(2'd0, 2'd3, 2'd2, 2'd0, 8'h00, 8'h33, 0, 0, 1, w);
      issue(2'd1, 2'd3, 2'd3, 2'd0, 8'h00, 8'h22, 0, 0, 1, w);
      chk("bp_alu_wait", w, 3);
      wait_done();
      chk("bp_rf2", rf[2], 8'h22);
      chk("bp_rf3", rf[3], 8'h22);
      // reset during READ_B aborts with no write
      issue(2'd0, 2'd0, 2'd1, 2'd1, 8'h00, 8'h00, 0, 0, 0, w);
      @(negedge clk);
      chk("abort_raddr", rf_read_address, 1);
      reset_b = 0;
      #1;
      chk("abort_ready", cmd_ready, 1);
      chk("abort_we", rf_write_enable, 0);
      repeat (2) @(negedge clk);
      chk("abort_we_hold", rf_write_enable, 0);
      reset_b = 1;
      chk("post_ready", cmd_ready, 1);
      chk("post_done", done, 0);
      chk("post_result", result, 0);
`ifdef REGSEQ_FLAGS_EN
      chk("post_flag_z", flag_z, 0);
      chk("post_flag_c", flag_c, 0);
`endif
      repeat (3) @(negedge clk);
      chk("abort_rf0", rf[0], 8'h11);
      chk("scoreboard_drained", q.size(), 0);
      chk("write_count", writes, exp_writes);
      chk("accept_count", accepts, exp_accepts);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Command-driven controller that sequences the 4 x 8-bit single-read-port register file through read-read-execute-writeback operations. It accepts one command at a time over a valid/ready handshake and drives the register file's read address, write address, write data and write enable. It reads operands through the register file's combinational read port, applies a small 8-bit ALU and reports completion with a one-cycle done pulse. It sits between the instruction/host logic and the register file.

## Interface
Parameters:
- none. Widths are fixed: data 8 bits, register address 2 bits.

Ports (clock and reset first):
- clk  input  1  rising-edge clock shared with the register file
- reset_b  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  2  00 ADD, 01 SUB, 10 AND, 11 LDI
- cmd_rd  input  2  destination register
- cmd_ra  input  2  operand A register
- cmd_rb  input  2  operand B register
- cmd_imm  input  8  immediate, used by LDI only
- rf_read_address  output  2  to register file read port
- rf_read_data  input  8  from register file, combinational in read_address
- rf_write_address  output  2  to register file
- rf_write_data  output  8  to register file
- rf_write_enable  output  1  to register file, commits on the rising clk edge
- done  output  1  one-cycle pulse after writeback
- result  output  8  value written by the last completed command, held until the next done

## Operation
- FSM states: IDLE, READ_A, READ_B, WRITE.
- IDLE: cmd_ready=1. When cmd_valid && cmd_ready, the op, rd, ra, rb and imm are captured. ADD/SUB/AND go to READ_A; LDI goes directly to WRITE.
- READ_A: rf_read_address=ra. rf_read_data is captured into opA at the clock edge. Next state is READ_B.
- READ_B: rf_read_address=rb. The value is captured into opB. Next state is WRITE.
- WRITE: rf_write_enable=1, rf_write_address=rd, rf_write_data=ALU result. Next state is IDLE. At the same edge, result is loaded and done is set for the following cycle.
- ALU results:
  - ADD: (opA+opB) mod 256.
  - SUB: (opA-opB) mod 256.
  - AND: opA & opB.
  - LDI: imm.
- In all other states cmd_ready=0. A command presented while busy is not accepted and must be held by the requester.
- rf_read_address outputs 0 in IDLE and WRITE. rf_write_enable is 0 outside WRITE.
- ra, rb and rd may alias each other, e.g. ADD r1,r1,r1 doubles r1.
- Reset (any state, asynchronous): the state returns to IDLE and an in-flight command is aborted with no write.
  - Output values after reset: cmd_ready=1, done=0, result=0x00, rf_write_enable=0, rf_read_address=0, rf_write_address=0, rf_write_data=0.

## Timing
- Edge E0 accepts the command.
- ADD/SUB/AND: READ_A runs in cycle 1, READ_B in cycle 2 and WRITE in cycle 3. The register file commits at E3. done=1 during cycle 4, and cmd_ready is also 1 in cycle 4.
- LDI: WRITE runs in cycle 1 and the commit is at E1. done=1 during cycle 2.
- Back-to-back commands: the next command can be accepted in the cycle in which done=1.
  - A following read of the just-written register returns the new value, because the write committed at the prior edge. No bypass is needed.
- Throughput: one ALU command per 4 cycles, or one LDI per 2 cycles.
- done is never high for two consecutive cycles.

## Configuration
- REGSEQ_FLAGS_EN:
  - Defined: adds output ports flag_z (1 bit) and flag_c (1 bit). Both are registered at the writeback edge, alongside result.
  - flag_z=1 when the written value is 0x00.
  - flag_c:
    - ADD: carry out of bit 7.
    - SUB: borrow, i.e. opA<opB.
    - AND and LDI: 0.
  - Both flags reset to 0.
- Undefined: the ports are absent and no flag logic is built.

## Test plan
- Reset test: hold reset_b=0 in the middle of an ADD in READ_B. Required: no rf_write_enable pulse, and after release cmd_ready=1, done=0, result=0x00.
- Load latency: LDI r2,#0x5A. Required: rf_write_enable=1 exactly one cycle after acceptance, done one cycle later, result=0x5A, and register 2 reads back 0x5A.
- Arithmetic and flags: with r0=0xF0 and r1=0x20, issue ADD r3,r0,r1.
  - Required: done in the 4th cycle after acceptance, result=0x10, r3=0x10.
  - With flags built in: flag_c=1, flag_z=0.
- Borrow and zero: with r0=0x10 and r1=0x20, SUB r2,r0,r1 gives 0xF0 with flag_c=1. AND r3,r0,r1 gives 0x00 with flag_z=1.
- Back-to-back and aliasing: LDI r1,#0x03 is followed in the done cycle by ADD r1,r1,r1. Required: the ADD is accepted on the done cycle, then result=0x06 and r1=0x06.
- Backpressure: hold cmd_valid=1 with a second command while busy. Required: cmd_ready=0 until done, exactly one acceptance per command, and no lost or duplicated writes.
